// File: rtl/rng_pkg.sv
// Shared definitions for the LFSR random number generators:
// primitive tap masks and the snake-game coordinate generator width.
package rng_pkg;

    localparam int RNG63_WIDTH = 6;
    localparam int LFSR_MIN_WIDTH = 3;
    localparam int LFSR_MAX_WIDTH = 8;

    // Tap masks for maximal-length Fibonacci LFSRs (bit i = state bit i feeds the XOR).
    // Unsupported widths return 0, which the generator rejects at elaboration.
    function automatic logic [7:0] lfsr_taps(input int width);
        logic [7:0] taps;
        case (width)
            3:       taps = 8'b0000_0110;
            4:       taps = 8'b0000_1100;
            5:       taps = 8'b0001_0100;
            6:       taps = 8'b0011_0000;
            7:       taps = 8'b0110_0000;
            8:       taps = 8'b1011_1000;
            default: taps = 8'b0000_0000;
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// One Fibonacci LFSR step: feedback is the XOR of the tapped bits,
// shifted in at bit 0 while the state moves one place left.
module lfsr_step
    import rng_pkg::*;
#(
    parameter int               WIDTH = RNG63_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(lfsr_taps(WIDTH))
) (
    input  logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] next_state
);

    logic feedback;

    assign feedback   = ^(state & TAPS);
    assign next_state = {state[WIDTH-2:0], feedback};

endmodule

// File: rtl/random_number_gen_63.sv
// Free-running maximal-length LFSR random number generator; the state register
// drives rnd directly and never holds zero after its first clock.
module random_number_gen_63
    import rng_pkg::*;
#(
    parameter int               WIDTH = RNG63_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(lfsr_taps(WIDTH))
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] rnd
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    if (WIDTH < LFSR_MIN_WIDTH || WIDTH > LFSR_MAX_WIDTH) begin : g_bad_width
        $fatal(1, "random_number_gen_63: WIDTH %0d outside supported range 3..8", WIDTH);
    end
    if (TAPS == '0) begin : g_bad_taps
        $fatal(1, "random_number_gen_63: TAPS must be non-zero");
    end

    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] step_next;

    lfsr_step #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_step (
        .state      (state),
        .next_state (step_next)
    );

    // All-zero is the XOR LFSR's stuck state, so both the seed load and the
    // free-running step substitute 1 whenever zero would otherwise be held.
    // NOTE: state is a flop, so it is updated with <= to avoid ordering races.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= (seed == '0) ? ONE : seed;
        end else if (state == '0) begin
            state <= ONE;
        end else begin
            state <= step_next;
        end
    end

    assign rnd = state;

endmodule

// File: tb/tb_random_number_gen_63.sv
// Self-checking bench for random_number_gen_63: directed vector table plus
// hand-written period and mid-run reset sequences.
module tb_random_number_gen_63;

    logic       clk;
    logic       reset;
    logic [5:0] seed;
    logic [5:0] rnd;

    int n_checks = 0;
    int n_fail   = 0;

    random_number_gen_63 dut (
        .clk   (clk),
        .reset (reset),
        .seed  (seed),
        .rnd   (rnd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       reset;
        logic [5:0] seed;
        logic [5:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive inputs, take one rising edge, sample 1 ns later.
    task automatic apply(input logic r, input logic [5:0] s);
        reset = r;
        seed  = s;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[$];
    bit   seen[64];
    logic [5:0] mid_exp[10];

    initial begin
        reset = 1'b1;
        seed  = 6'd0;

        // Seed 38 then four steps; a seed change while running is ignored.
        vecs.push_back('{"t1_reset",  1'b0, 6'd38, 6'd38});
        vecs.push_back('{"t1_step1",  1'b1, 6'd38, 6'd13});
        vecs.push_back('{"t1_step2",  1'b1, 6'd0,  6'd26});
        vecs.push_back('{"t1_step3",  1'b1, 6'd38, 6'd53});
        vecs.push_back('{"t1_step4",  1'b1, 6'd38, 6'd42});
        // Seed 41.
        vecs.push_back('{"t2_reset",  1'b0, 6'd41, 6'd41});
        vecs.push_back('{"t2_step1",  1'b1, 6'd41, 6'd19});
        vecs.push_back('{"t2_step2",  1'b1, 6'd41, 6'd39});
        // Zero seed is guarded to 1.
        vecs.push_back('{"t3_reset0", 1'b0, 6'd0,  6'd1});
        vecs.push_back('{"t3_step1",  1'b1, 6'd0,  6'd2});
        vecs.push_back('{"t3_step2",  1'b1, 6'd0,  6'd4});
        // Reset held: last sampled seed wins, then step from 9.
        vecs.push_back('{"t6_hold5",  1'b0, 6'd5,  6'd5});
        vecs.push_back('{"t6_hold7",  1'b0, 6'd7,  6'd7});
        vecs.push_back('{"t6_hold9",  1'b0, 6'd9,  6'd9});
        vecs.push_back('{"t6_rel",    1'b1, 6'd9,  6'd18});

        // Let the register leave any power-up value before the table starts.
        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].reset, vecs[i].seed);
            check(vecs[i].name, rnd, vecs[i].exp);
        end

        // Full period from seed 38: every non-zero value exactly once, back to 38 on edge 63.
        apply(1'b0, 6'd38);
        check("t4_reset", rnd, 6'd38);
        for (int i = 0; i < 64; i++) seen[i] = 1'b0;
        for (int e = 1; e <= 63; e++) begin
            apply(1'b1, 6'd38);
            n_checks++;
            if (rnd == 6'd0 || seen[rnd]) begin
                n_fail++;
                $display("FAIL t4_unique: edge %0d got %0d (zero or repeated), required a new non-zero value", e, rnd);
            end else begin
                seen[rnd] = 1'b1;
            end
        end
        check("t4_wrap", rnd, 6'd38);

        // Mid-run reset: seed changes while running do nothing, reset reloads.
        mid_exp = '{6'd13, 6'd26, 6'd53, 6'd42, 6'd21, 6'd43, 6'd23, 6'd47, 6'd31, 6'd63};
        apply(1'b0, 6'd38);
        check("t5_reset", rnd, 6'd38);
        for (int e = 0; e < 10; e++) begin
            apply(1'b1, 6'd38);
            check($sformatf("t5_run%0d", e + 1), rnd, mid_exp[e]);
        end
        apply(1'b1, 6'd41);
        check("t5_seed_ignored", rnd, 6'd62);
        apply(1'b0, 6'd41);
        check("t5_reload", rnd, 6'd41);
        apply(1'b1, 6'd41);
        check("t5_after_reload", rnd, 6'd19);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
